// File: rtl/ps2_cmd_decoder_if.sv
// ps2_cmd_decoder_if: byte stream in, held/pulsed game commands and last scan code out.
interface ps2_cmd_decoder_if #(
    parameter int NUM_CMDS = 4
);
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [NUM_CMDS-1:0] cmd;
    logic [NUM_CMDS-1:0] cmd_pulse;
    logic [8:0]          last_code;
    logic                last_break;
    modport master (output rx_data, rx_valid, input cmd, cmd_pulse, last_code, last_break);
    modport slave (input rx_data, rx_valid, output cmd, cmd_pulse, last_code, last_break);
endinterface

// File: rtl/ps2_cmd_decoder.sv
// ps2_cmd_decoder: parses E0/F0 prefixed PS/2 scan codes into one-hot held game commands.
module ps2_cmd_decoder #(
    parameter int                    NUM_CMDS    = 4,
    parameter logic [9*NUM_CMDS-1:0] KEYMAP      = {9'h023, 9'h01C, 9'h01B, 9'h01D},
    parameter int                    HOLD_CYCLES = 1800000,
    parameter int                    CNT_W       = 21,
    parameter int                    MODE        = 0
) (
    input logic clk,
    input logic reset,
    ps2_cmd_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                is_e0, is_f0, done, seq_ext, seq_brk, hit;
    logic [8:0]          seq;
    logic [NUM_CMDS-1:0] hot;
    assign is_e0   = bus.rx_data == 8'hE0;
    assign is_f0   = bus.rx_data == 8'hF0;
    assign done    = bus.rx_valid && !is_e0 && !is_f0;
    assign seq_ext = state == EXT || state == EXT_BRK;
    assign seq_brk = state == BRK || state == EXT_BRK;
    assign seq     = {seq_ext, bus.rx_data};
    assign hit     = |hot;
    // scanning downward lets the lowest matching index overwrite higher ones
    always_comb begin
        hot = '0;
        for (int i = NUM_CMDS - 1; i >= 0; i--)
            if (KEYMAP[9*i +: 9] == seq) begin
                hot    = '0;
                hot[i] = 1'b1;
            end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.cmd        <= '0;
            bus.cmd_pulse  <= '0;
            bus.last_code  <= '0;
            bus.last_break <= 1'b0;
        end else begin
            bus.cmd_pulse <= '0;
            if (bus.rx_valid)
                state <= is_e0 ? (seq_brk ? EXT_BRK : EXT) : is_f0 ? (seq_ext ? EXT_BRK : BRK) : IDLE;
            if (MODE != 1 && bus.cmd != '0) begin
                if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    bus.cmd <= '0;
                    cnt     <= '0;
                end else
                    cnt <= cnt + 1'b1;
            end
            // a make issued on the timeout edge overrides the clear above
            if (done) begin
                bus.last_code  <= seq;
                bus.last_break <= seq_brk;
                if (hit && !seq_brk) begin
                    bus.cmd       <= hot;
                    bus.cmd_pulse <= hot;
                    cnt           <= '0;
                end else if (hit && MODE != 0 && |(hot & bus.cmd)) begin
                    bus.cmd <= '0;
                    cnt     <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// tb_ps2_cmd_decoder: three decoders (timed, level, timed-or-break) fed one byte stream and
// checked every cycle against a prefix-flag/countdown reference model.
module tb_ps2_cmd_decoder;
    localparam int H = 8;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;

    ps2_cmd_decoder_if #(.NUM_CMDS(4)) b0();
    ps2_cmd_decoder_if #(.NUM_CMDS(4)) b1();
    ps2_cmd_decoder_if #(.NUM_CMDS(4)) b2();
    assign b0.rx_data = rx_data;
    assign b0.rx_valid = rx_valid;
    assign b1.rx_data = rx_data;
    assign b1.rx_valid = rx_valid;
    assign b2.rx_data = rx_data;
    assign b2.rx_valid = rx_valid;

    ps2_cmd_decoder #(.NUM_CMDS(4), .HOLD_CYCLES(H), .CNT_W(4), .MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    ps2_cmd_decoder #(.NUM_CMDS(4), .KEYMAP({9'h01D, 9'h16B, 9'h01B, 9'h01D}), .HOLD_CYCLES(H), .CNT_W(4), .MODE(1))
        dut1 (.clk(clk), .reset(reset), .bus(b1));
    ps2_cmd_decoder #(.NUM_CMDS(4), .HOLD_CYCLES(H), .CNT_W(4), .MODE(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

    int         mode_m[3];
    logic [8:0] km[3][4];
    int         act[3], rem[3], pul[3];
    bit         ext_f[3], brk_f[3], lb[3];
    logic [8:0] lc[3];
    logic [7:0] pool[8];

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            act[m] = -1; rem[m] = 0; pul[m] = -1;
            ext_f[m] = 0; brk_f[m] = 0; lb[m] = 0; lc[m] = 9'h000;
        end
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        int k;
        logic [8:0] code;
        for (int m = 0; m < 3; m++) begin
            pul[m] = -1;
            if (act[m] >= 0 && mode_m[m] != 1) begin
                rem[m]--;
                if (rem[m] == 0) act[m] = -1;
            end
            if (v) begin
                if (d == 8'hE0) ext_f[m] = 1;
                else if (d == 8'hF0) brk_f[m] = 1;
                else begin
                    code = {ext_f[m], d};
                    lc[m] = code;
                    lb[m] = brk_f[m];
                    k = -1;
                    for (int e = 0; e < 4; e++) if (k < 0 && km[m][e] == code) k = e;
                    if (k >= 0 && !brk_f[m]) begin
                        act[m] = k; rem[m] = H; pul[m] = k;
                    end else if (k >= 0 && mode_m[m] != 0 && act[m] == k) act[m] = -1;
                    ext_f[m] = 0; brk_f[m] = 0;
                end
            end
        end
    endtask

    task automatic check(input int m, input logic [3:0] c, input logic [3:0] p, input logic [8:0] lco, input logic lbo);
        logic [3:0] ec, ep;
        ec = act[m] >= 0 ? 4'(1 << act[m]) : 4'd0;
        ep = pul[m] >= 0 ? 4'(1 << pul[m]) : 4'd0;
        checks++;
        assert (c === ec) else begin errors++; $error("FAIL cmd[%0d] got %b want %b", m, c, ec); end
        checks++;
        assert (p === ep) else begin errors++; $error("FAIL cmd_pulse[%0d] got %b want %b", m, p, ep); end
        checks++;
        assert (lco === lc[m]) else begin errors++; $error("FAIL last_code[%0d] got %h want %h", m, lco, lc[m]); end
        checks++;
        assert (lbo === lb[m]) else begin errors++; $error("FAIL last_break[%0d] got %b want %b", m, lbo, lb[m]); end
    endtask

    task automatic check_all();
        check(0, b0.cmd, b0.cmd_pulse, b0.last_code, b0.last_break);
        check(1, b1.cmd, b1.cmd_pulse, b1.last_code, b1.last_break);
        check(2, b2.cmd, b2.cmd_pulse, b2.last_code, b2.last_break);
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data = d;
        @(posedge clk);
        model_step(v, d);
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        mode_m = '{0, 1, 2};
        km[0] = '{9'h01D, 9'h01B, 9'h01C, 9'h023};
        km[1] = '{9'h01D, 9'h01B, 9'h16B, 9'h01D};
        km[2] = '{9'h01D, 9'h01B, 9'h01C, 9'h023};
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h6B, 8'h2A};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        idle(2);
        send(8'h1D); idle(10);
        send(8'h1B); idle(2); send(8'h23); idle(7); send(8'h23); idle(10);
        send(8'hE0); send(8'h6B); idle(2);
        send(8'h6B); idle(1);
        send(8'hE0); send(8'hF0); send(8'h6B); idle(2);
        send(8'h1C); send(8'hF0); send(8'h1D); idle(1); send(8'hF0); send(8'h1C); idle(10);
        send(8'h2A); idle(1);
        send(8'hF0); send(8'hF0); send(8'hE0); send(8'h1D); idle(1);
        send(8'h1D); idle(4); send(8'hE0);
        async_reset();
        send(8'h1D); idle(10);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            if ($urandom_range(0, 2) == 0)
                send($urandom_range(0, 4) == 0 ? 8'($urandom) : pool[$urandom_range(0, 7)]);
            else
                idle(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
